// File: rtl/tbus_pkg.sv
// tbus_pkg: shared types and width helpers for tristate_bus_arbiter.
//   tbus_state_t : arbiter FSM states (TURN is only reachable when
//                  TRISTATE_BUS_TURNAROUND_EN is defined).
//   id_width()   : bits needed for a channel index.
//   cnt_width()  : bits needed for a hold counter reaching max_hold.
package tbus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } tbus_state_t;

  function automatic int unsigned id_width(input int unsigned n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_hold);
    return $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority picker.
//   req       : per-channel request vector
//   base      : highest-priority channel index this round
//   winner    : one-hot grant of the first requester at or after base (wrapping)
//   winner_id : index of winner, 0 when none
//   valid     : any request present
module rr_pick
  import tbus_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned ID_W = id_width(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [ID_W-1:0] base,
  output logic [N_CH-1:0] winner,
  output logic [ID_W-1:0] winner_id,
  output logic            valid
);

  // Two ascending scans: first among channels >= base, then wrap to the
  // lowest index. Equivalent to a rotate-by-base priority encoder.
  always_comb begin
    winner    = '0;
    winner_id = '0;
    valid     = 1'b0;
    for (int unsigned j = 0; j < N_CH; j++) begin
      if (!valid && req[j] && (j >= 32'(base))) begin
        valid     = 1'b1;
        winner[j] = 1'b1;
        winner_id = ID_W'(j);
      end
    end
    for (int unsigned j = 0; j < N_CH; j++) begin
      if (!valid && req[j]) begin
        valid     = 1'b1;
        winner[j] = 1'b1;
        winner_id = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter: round-robin owner of a shared WIDTH-bit bus with a
// hold-time limit. bus_oe drives the pad TBUF enables.
//   clk, rst     : clock, synchronous active-high reset
//   req          : per-channel level requests
//   data_in      : channel c data at [c*WIDTH +: WIDTH]
//   bus_out      : owner's data, 0 when bus_oe=0 (no register on this path)
//   bus_oe       : bus driven
//   grant        : one-hot owner, zero when released
//   owner_id     : owner index, 0 when none
//   hold_expired : one-cycle pulse when the owner is force-released
// Optional macro TRISTATE_BUS_TURNAROUND_EN: insert one released TURN cycle
// on every owner change (and before going IDLE).
module tristate_bus_arbiter
  import tbus_pkg::*;
#(
  parameter  int unsigned N_CH     = 4,
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned MAX_HOLD = 16,
  localparam int unsigned ID_W     = id_width(N_CH),
  localparam int unsigned CNT_W    = cnt_width(MAX_HOLD)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       req,
  input  logic [N_CH*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]      bus_out,
  output logic                  bus_oe,
  output logic [N_CH-1:0]       grant,
  output logic [ID_W-1:0]       owner_id,
  output logic                  hold_expired
);

  tbus_state_t      state;
  logic [CNT_W-1:0] hold_cnt;
  logic [ID_W-1:0]  last;

  logic [ID_W-1:0]  start;
  logic [N_CH-1:0]  pick_oh;
  logic [ID_W-1:0]  pick_id;
  logic             pick_valid;
  logic             owner_req;
  logic             others_req;
  logic             hold_hit;

  always_comb begin
    start      = (last == ID_W'(N_CH - 1)) ? '0 : last + 1'b1;
    owner_req  = |(req & grant);
    others_req = |(req & ~grant);
    hold_hit   = (hold_cnt == CNT_W'(MAX_HOLD));
  end

  // last+1 as base makes a force-released owner that still requests the
  // lowest priority, while still letting it win when it is alone.
  rr_pick #(
    .N_CH (N_CH),
    .ID_W (ID_W)
  ) u_pick (
    .req       (req),
    .base      (start),
    .winner    (pick_oh),
    .winner_id (pick_id),
    .valid     (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grant        <= '0;
      bus_oe       <= 1'b0;
      owner_id     <= '0;
      hold_expired <= 1'b0;
      hold_cnt     <= '0;
      last         <= ID_W'(N_CH - 1);
    end else begin
      hold_expired <= 1'b0;
      case (state)
        IDLE: begin
          hold_cnt <= '0;
          if (pick_valid) begin
            state    <= OWN;
            grant    <= pick_oh;
            owner_id <= pick_id;
            last     <= pick_id;
            bus_oe   <= 1'b1;
          end
        end
        OWN: begin
          if (!owner_req || hold_hit) begin
            // A voluntary release wins over a coincident expiry: no pulse.
            hold_expired <= owner_req;
            hold_cnt     <= '0;
`ifdef TRISTATE_BUS_TURNAROUND_EN
            state    <= TURN;
            grant    <= '0;
            owner_id <= '0;
            bus_oe   <= 1'b0;
`else
            if (pick_valid) begin
              grant    <= pick_oh;
              owner_id <= pick_id;
              last     <= pick_id;
            end else begin
              state    <= IDLE;
              grant    <= '0;
              owner_id <= '0;
              bus_oe   <= 1'b0;
            end
`endif
          end else if (others_req) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
`ifdef TRISTATE_BUS_TURNAROUND_EN
        TURN: begin
          hold_cnt <= '0;
          if (pick_valid) begin
            state    <= OWN;
            grant    <= pick_oh;
            owner_id <= pick_id;
            last     <= pick_id;
            bus_oe   <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
`endif
        default: begin
          state    <= IDLE;
          grant    <= '0;
          owner_id <= '0;
          bus_oe   <= 1'b0;
          hold_cnt <= '0;
        end
      endcase
    end
  end

  // Select by the registered one-hot grant; grant is zero when released.
  always_comb begin
    bus_out = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (bus_oe && grant[c]) begin
        bus_out = data_in[c*WIDTH +: WIDTH];
      end
    end
  end

endmodule
